pipeline_ctrl: RTL

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

---
 rtl/pipeline_ctrl.sv | 122 ++++++++++++
 1 files changed

// File: rtl/pipeline_ctrl.sv
// Five-stage pipeline stall/flush controller with a multi-cycle data memory handshake.
// The memory wait is guarded by a watchdog that locks into a sticky error state.
module pipeline_ctrl #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             hz_stall_i,
    input  logic             branch_i,
    input  logic             mem_req_i,
    input  logic             mem_ack_i,
    output logic             pc_write_o,
    output logic             ifid_write_o,
    output logic             ifid_flush_o,
    output logic             idex_bubble_o,
    output logic             exmem_write_o,
    output logic             memwb_write_o,
    output logic             mem_req_o,
    output logic             err_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    typedef enum logic [1:0] {StRun, StMemWait, StError} state_e;

    localparam logic [15:0]      TimeoutW = 16'(TIMEOUT);
    localparam logic [CNT_W-1:0] CntMax   = '1;

    state_e           state_q, state_d;
    logic [15:0]      wd_q, wd_d;
    logic             mem_req_q, mem_req_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             freeze;

    always_comb begin
        state_d       = state_q;
        wd_d          = wd_q;
        freeze        = 1'b0;
        pc_write_o    = 1'b1;
        ifid_write_o  = 1'b1;
        ifid_flush_o  = 1'b0;
        idex_bubble_o = 1'b0;
        exmem_write_o = 1'b1;
        memwb_write_o = 1'b1;

        unique case (state_q)
            StRun: begin
                wd_d = '0;
                // mem_req_i outranks hz_stall_i, which outranks branch_i
                if (mem_req_i) begin
                    freeze  = 1'b1;
                    state_d = StMemWait;
                end else if (hz_stall_i) begin
                    pc_write_o    = 1'b0;
                    ifid_write_o  = 1'b0;
                    idex_bubble_o = 1'b1;
                end else if (branch_i) begin
                    ifid_flush_o = 1'b1;
                end
            end
            StMemWait: begin
                // An ack on the timeout cycle still releases the pipeline
                if (mem_ack_i) begin
                    state_d = StRun;
                    wd_d    = '0;
                end else begin
                    freeze = 1'b1;
                    if (wd_q >= TimeoutW) begin
                        state_d = StError;
                    end else begin
                        wd_d = wd_q + 16'd1;
                    end
                end
            end
            StError: freeze = 1'b1;
            default: begin
                freeze  = 1'b1;
                state_d = StRun;
            end
        endcase

        if (freeze || rst_i) begin
            pc_write_o    = 1'b0;
            ifid_write_o  = 1'b0;
            ifid_flush_o  = 1'b0;
            idex_bubble_o = 1'b0;
            exmem_write_o = 1'b0;
            memwb_write_o = 1'b0;
        end
    end

    always_comb begin
        mem_req_d = (state_d == StMemWait);
        err_d     = err_q | (state_d == StError);
        cnt_d     = cnt_q;
        if (!pc_write_o && cnt_q != CntMax) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= StRun;
            wd_q      <= '0;
            mem_req_q <= 1'b0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            wd_q      <= wd_d;
            mem_req_q <= mem_req_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
        end
    end

    assign mem_req_o   = mem_req_q;
    assign err_o       = err_q;
    assign stall_cnt_o = cnt_q;

endmodule
